// File: rtl/axis_frame_gen_pkg.sv
// Shared types and constants for the AXI4-Stream frame generator.
// PRBS constants are only consumed when AXIS_FRAME_GEN_PRBS_EN is defined.
package axis_frame_gen_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2
   } state_t;

   // PRBS31, x^31 + x^28 + 1, Fibonacci form
   localparam int unsigned PRBS_LEN    = 31;
   localparam int unsigned PRBS_TAP_HI = 30;
   localparam int unsigned PRBS_TAP_LO = 27;
   localparam logic [PRBS_LEN-1:0] PRBS_SEED = '1;

endpackage

// File: rtl/axis_frame_gen_if.sv
// AXI4-Stream bundle between the frame generator (master) and its consumer (slave).
interface axis_frame_gen_if #(
   parameter int DATA_WIDTH = 8,
   parameter int USER_WIDTH = 1
);
   localparam int KEEP_WIDTH = DATA_WIDTH / 8;

   logic [DATA_WIDTH-1:0] tdata;
   logic [KEEP_WIDTH-1:0] tkeep;
   logic                  tvalid;
   logic                  tready;
   logic                  tlast;
   logic [USER_WIDTH-1:0] tuser;

   modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
   modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/axis_frame_gen_prbs.sv
// Parallel PRBS31 source: produces DATA_WIDTH fresh bits per load/advance.
// data is registered and holds whenever neither load nor advance is asserted.
module axis_frame_gen_prbs
   import axis_frame_gen_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load,
   input  logic                  advance,
   output logic [DATA_WIDTH-1:0] data
);

   logic [PRBS_LEN-1:0]   state_q;
   logic [PRBS_LEN-1:0]   state_nxt;
   logic [DATA_WIDTH-1:0] chunk;
   logic                  fb;

   // Unroll DATA_WIDTH serial steps; the first generated bit lands in the MSB.
   always_comb begin
      state_nxt = load ? PRBS_SEED : state_q;
      chunk     = '0;
      fb        = 1'b0;
      for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
         fb        = state_nxt[PRBS_TAP_HI] ^ state_nxt[PRBS_TAP_LO];
         state_nxt = {state_nxt[PRBS_LEN-2:0], fb};
         chunk[DATA_WIDTH-1-i] = fb;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= PRBS_SEED;
         data    <= '0;
      end else if (load || advance) begin
         state_q <= state_nxt;
         data    <= chunk;
      end
   end

endmodule

// File: rtl/axis_frame_gen.sv
// AXI4-Stream test frame generator: fixed-length frames, idle gaps, bad-frame tuser marker.
// Define AXIS_FRAME_GEN_PRBS_EN to source tdata from PRBS31 instead of the byte counter.
module axis_frame_gen
   import axis_frame_gen_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int KEEP_WIDTH = DATA_WIDTH / 8,
   parameter int LEN_WIDTH  = 16,
   parameter int GAP_WIDTH  = 8,
   parameter int USER_WIDTH = 1,
   parameter logic [USER_WIDTH-1:0] USER_BAD_FRAME_VALUE = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [LEN_WIDTH-1:0] cfg_frame_len,
   input  logic [LEN_WIDTH-1:0] cfg_frame_count,
   input  logic [GAP_WIDTH-1:0] cfg_gap,
   input  logic                 cfg_mark_bad,
   input  logic                 start,
   input  logic                 stop,
   axis_frame_gen_if.master     m_axis,
   output logic                 status_busy,
   output logic [LEN_WIDTH-1:0] status_frames_sent,
   output logic                 status_done
);

   state_t                state_q, state_d;
   logic [LEN_WIDTH-1:0]  len_q, len_d, count_q, count_d;
   logic [GAP_WIDTH-1:0]  gap_q, gap_d, gap_cnt_q, gap_cnt_d;
   logic                  mark_q, mark_d, stop_q, stop_d;
   logic [LEN_WIDTH-1:0]  beat_q, beat_d, frames_q, frames_d;
   logic [7:0]            byte_q, byte_d;
   logic                  busy_q, busy_d, done_q, done_d;
   logic                  valid_q, valid_d, last_q, last_d;
   logic [USER_WIDTH-1:0] user_q, user_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;

   logic                  hs, stop_any, run_start;
   logic [LEN_WIDTH-1:0]  beat_inc, frames_inc, len_m1;
   logic [7:0]            byte_inc;

   assign hs         = valid_q && m_axis.tready;
   assign stop_any   = stop_q || stop;
   assign run_start  = (state_q == IDLE) && start && (cfg_frame_len != '0);
   assign beat_inc   = beat_q + 1'b1;
   assign frames_inc = frames_q + 1'b1;
   assign len_m1     = len_q - 1'b1;
   assign byte_inc   = byte_q + 8'(KEEP_WIDTH);

   function automatic logic [DATA_WIDTH-1:0] count_pattern(input logic [7:0] base);
      logic [DATA_WIDTH-1:0] p;
      p = '0;
      for (int unsigned k = 0; k < KEEP_WIDTH; k++) p[8*k +: 8] = base + 8'(k);
      return p;
   endfunction

   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      count_d   = count_q;
      gap_d     = gap_q;
      mark_d    = mark_q;
      stop_d    = stop_q;
      beat_d    = beat_q;
      byte_d    = byte_q;
      gap_cnt_d = gap_cnt_q;
      frames_d  = frames_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      valid_d   = valid_q;
      last_d    = last_q;
      user_d    = user_q;
      data_d    = data_q;

      if (state_q != IDLE && stop) stop_d = 1'b1;

      unique case (state_q)
         IDLE: begin
            if (run_start) begin
               state_d  = SEND;
               len_d    = cfg_frame_len;
               count_d  = cfg_frame_count;
               gap_d    = cfg_gap;
               mark_d   = cfg_mark_bad;
               stop_d   = 1'b0;
               beat_d   = '0;
               byte_d   = '0;
               frames_d = '0;
               busy_d   = 1'b1;
               valid_d  = 1'b1;
               last_d   = (cfg_frame_len == LEN_WIDTH'(1));
               user_d   = (last_d && cfg_mark_bad) ? USER_BAD_FRAME_VALUE : '0;
               data_d   = count_pattern('0);
            end
         end
         SEND: begin
            if (hs) begin
               byte_d = byte_inc;
               if (last_q) begin
                  frames_d = frames_inc;
                  // A stop seen on this very edge still ends the run here.
                  if (stop_any || (count_q != '0 && frames_inc == count_q)) begin
                     state_d = IDLE;
                     busy_d  = 1'b0;
                     done_d  = 1'b1;
                     stop_d  = 1'b0;
                     valid_d = 1'b0;
                     last_d  = 1'b0;
                     user_d  = '0;
                  end else if (gap_q == '0) begin
                     beat_d = '0;
                     last_d = (len_q == LEN_WIDTH'(1));
                     user_d = (last_d && mark_q) ? USER_BAD_FRAME_VALUE : '0;
                     data_d = count_pattern(byte_inc);
                  end else begin
                     state_d   = GAP;
                     gap_cnt_d = gap_q;
                     valid_d   = 1'b0;
                     last_d    = 1'b0;
                     user_d    = '0;
                  end
               end else begin
                  beat_d = beat_inc;
                  last_d = (beat_inc == len_m1);
                  user_d = (last_d && mark_q) ? USER_BAD_FRAME_VALUE : '0;
                  data_d = count_pattern(byte_inc);
               end
            end
         end
         GAP: begin
            if (stop_any) begin
               state_d = IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               stop_d  = 1'b0;
            end else if (gap_cnt_q <= GAP_WIDTH'(1)) begin
               state_d = SEND;
               valid_d = 1'b1;
               beat_d  = '0;
               last_d  = (len_q == LEN_WIDTH'(1));
               user_d  = (last_d && mark_q) ? USER_BAD_FRAME_VALUE : '0;
               data_d  = count_pattern(byte_q);
            end else begin
               gap_cnt_d = gap_cnt_q - 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         len_q     <= '0;
         count_q   <= '0;
         gap_q     <= '0;
         mark_q    <= 1'b0;
         stop_q    <= 1'b0;
         beat_q    <= '0;
         byte_q    <= '0;
         gap_cnt_q <= '0;
         frames_q  <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         valid_q   <= 1'b0;
         last_q    <= 1'b0;
         user_q    <= '0;
         data_q    <= '0;
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         count_q   <= count_d;
         gap_q     <= gap_d;
         mark_q    <= mark_d;
         stop_q    <= stop_d;
         beat_q    <= beat_d;
         byte_q    <= byte_d;
         gap_cnt_q <= gap_cnt_d;
         frames_q  <= frames_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         valid_q   <= valid_d;
         last_q    <= last_d;
         user_q    <= user_d;
         data_q    <= data_d;
      end
   end

`ifdef AXIS_FRAME_GEN_PRBS_EN
   logic [DATA_WIDTH-1:0] prbs_data;

   axis_frame_gen_prbs #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_prbs (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (run_start),
      .advance (hs),
      .data    (prbs_data)
   );

   assign m_axis.tdata = prbs_data;
`else
   assign m_axis.tdata = data_q;
`endif

   assign m_axis.tkeep       = '1;
   assign m_axis.tvalid      = valid_q;
   assign m_axis.tlast       = last_q;
   assign m_axis.tuser       = user_q;
   assign status_busy        = busy_q;
   assign status_frames_sent = frames_q;
   assign status_done        = done_q;

endmodule

// File: tb/tb_axis_frame_gen.sv
// Self-checking bench for axis_frame_gen: stream-level reference model plus directed scenarios.
module tb_axis_frame_gen;

   localparam int DW  = 8;
   localparam int KW  = DW / 8;
   localparam int LW  = 16;
   localparam int GW  = 8;
   localparam int UW  = 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [LW-1:0] cfg_frame_len = '0;
   logic [LW-1:0] cfg_frame_count = '0;
   logic [GW-1:0] cfg_gap = '0;
   logic          cfg_mark_bad = 1'b0;
   logic          start = 1'b0;
   logic          stop = 1'b0;
   logic          status_busy;
   logic [LW-1:0] status_frames_sent;
   logic          status_done;

   axis_frame_gen_if #(.DATA_WIDTH(DW), .USER_WIDTH(UW)) axis ();

   axis_frame_gen #(
      .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .LEN_WIDTH(LW), .GAP_WIDTH(GW),
      .USER_WIDTH(UW), .USER_BAD_FRAME_VALUE(1'b1)
   ) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .cfg_frame_len      (cfg_frame_len),
      .cfg_frame_count    (cfg_frame_count),
      .cfg_gap            (cfg_gap),
      .cfg_mark_bad       (cfg_mark_bad),
      .start              (start),
      .stop               (stop),
      .m_axis             (axis),
      .status_busy        (status_busy),
      .status_frames_sent (status_frames_sent),
      .status_done        (status_done)
   );

   always #5 clk = ~clk;

   int unsigned n_total = 0;
   int unsigned n_pass  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // Beat log and event timestamps, in negedge cycle numbers.
   int          cyc = 0;
   logic [DW-1:0] log_data[$];
   logic        log_last[$];
   logic        log_user[$];
   int          log_cyc[$];
   int          start_cyc = -1, stop_cyc = -1, done_cyc = -1;
   int          done_cnt = 0;

   // Reference model state: value expected to be visible at the next negedge.
   bit          exp_reset = 1'b1;
   bit          exp_done = 1'b0;
   bit          m_busy = 1'b0, m_pres = 1'b0, m_stop = 1'b0, m_mark = 1'b0;
   int          m_len = 0, m_count = 0, m_gap = 0, m_gap_left = 0;
   int          m_n = 0, m_frames = 0;

   function automatic logic [DW-1:0] exp_data(input int n);
      logic [DW-1:0] p;
      int base;
      base = (n * KW) % 256;
      for (int k = 0; k < KW; k++) p[8*k +: 8] = 8'((base + k) % 256);
      return p;
   endfunction

   always @(negedge clk) begin
      bit exp_last;
      cyc++;
      if (axis.tvalid && axis.tready) begin
         log_data.push_back(axis.tdata);
         log_last.push_back(axis.tlast);
         log_user.push_back(axis.tuser[0]);
         log_cyc.push_back(cyc);
      end
      if (status_done) begin done_cyc = cyc; done_cnt++; end
      if (start) start_cyc = cyc;
      if (stop) stop_cyc = cyc;

      // Compare current outputs against the model.
      check("tvalid", axis.tvalid, m_pres);
      check("busy", status_busy, m_busy);
      check("done", status_done, exp_done);
      check("frames_sent", status_frames_sent, LW'(m_frames));
      if (exp_reset) begin
         check("rst_tdata", axis.tdata, '0);
         check("rst_tlast", axis.tlast, 1'b0);
         check("rst_tuser", axis.tuser, 1'b0);
      end else if (m_pres) begin
         exp_last = ((m_n % m_len) == m_len - 1);
         check("tdata", axis.tdata, exp_data(m_n));
         check("tlast", axis.tlast, exp_last);
         check("tuser", axis.tuser, exp_last && m_mark);
         check("tkeep", axis.tkeep, {KW{1'b1}});
      end

      // Advance the model using the inputs that the coming posedge samples.
      exp_done = 1'b0;
      if (!rst_n) begin
         exp_reset = 1'b1;
         m_busy = 0; m_pres = 0; m_stop = 0; m_frames = 0; m_n = 0;
      end else begin
         exp_reset = 1'b0;
         if (!m_busy) begin
            if (start && cfg_frame_len != 0) begin
               m_len = int'(cfg_frame_len); m_count = int'(cfg_frame_count);
               m_gap = int'(cfg_gap); m_mark = cfg_mark_bad;
               m_busy = 1; m_pres = 1; m_stop = 0; m_n = 0; m_frames = 0;
            end
         end else begin
            if (stop) m_stop = 1;
            if (m_pres) begin
               if (axis.tready) begin
                  m_n++;
                  if (m_n % m_len == 0) begin
                     m_frames++;
                     if (m_stop || (m_count != 0 && m_frames == m_count)) begin
                        m_busy = 0; m_pres = 0; m_stop = 0; exp_done = 1;
                     end else if (m_gap != 0) begin
                        m_pres = 0; m_gap_left = m_gap;
                     end
                  end
               end
            end else if (m_stop) begin
               m_busy = 0; m_stop = 0; exp_done = 1;
            end else begin
               m_gap_left--;
               if (m_gap_left == 0) m_pres = 1;
            end
         end
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_log();
      log_data.delete(); log_last.delete(); log_user.delete(); log_cyc.delete();
   endtask

   task automatic do_start(input int len, input int count, input int gap, input bit mark);
      cfg_frame_len = LW'(len); cfg_frame_count = LW'(count);
      cfg_gap = GW'(gap); cfg_mark_bad = mark;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input bit toggle, input int budget);
      int d0;
      d0 = done_cnt;
      for (int i = 0; i < budget && done_cnt == d0; i++) begin
         if (toggle) axis.tready = ~axis.tready;
         tick();
      end
      axis.tready = 1'b1;
      if (done_cnt == d0) check("done_timeout", 1'b0, 1'b1);
   endtask

   task automatic wait_beats(input int n, input int budget);
      for (int i = 0; i < budget && log_data.size() < n; i++) tick();
      if (log_data.size() < n) check("beat_timeout", 64'(log_data.size()), 64'(n));
   endtask

   initial begin
      axis.tready = 1'b1;
      rst_n = 1'b0;
      tick(3);
      check("rst_valid", axis.tvalid, 1'b0);
      check("rst_busy", status_busy, 1'b0);
      check("rst_frames", status_frames_sent, '0);
      rst_n = 1'b1;
      tick(2);

      // Basic run: 2 frames of 4 beats, back-to-back.
      clear_log();
      do_start(4, 2, 0, 0);
      wait_done(1'b0, 100);
      tick();
      check("basic_beats", 64'(log_data.size()), 64'd8);
      for (int i = 0; i < 8 && i < log_data.size(); i++) begin
         check("basic_data", log_data[i], 8'(i));
         check("basic_last", log_last[i], (i == 3 || i == 7));
      end
      if (log_cyc.size() == 8) begin
         check("basic_latency", 64'(log_cyc[0]), 64'(start_cyc + 1));
         check("basic_done_at", 64'(done_cyc), 64'(log_cyc[7] + 1));
      end
      check("basic_frames", status_frames_sent, 16'd2);
      check("basic_busy", status_busy, 1'b0);

      // Backpressure: tready toggles every cycle.
      clear_log();
      do_start(3, 1, 0, 0);
      wait_done(1'b1, 100);
      tick();
      check("bp_beats", 64'(log_data.size()), 64'd3);
      for (int i = 0; i < 3 && i < log_data.size(); i++) begin
         check("bp_data", log_data[i], 8'(i));
         check("bp_last", log_last[i], (i == 2));
      end

      // Gap of 5 idle cycles between frames.
      clear_log();
      do_start(2, 3, 5, 0);
      wait_done(1'b0, 200);
      tick();
      check("gap_beats", 64'(log_data.size()), 64'd6);
      if (log_cyc.size() == 6) begin
         check("gap_b2b", 64'(log_cyc[1] - log_cyc[0]), 64'd1);
         check("gap_idle1", 64'(log_cyc[2] - log_cyc[1] - 1), 64'd5);
         check("gap_idle2", 64'(log_cyc[4] - log_cyc[3] - 1), 64'd5);
         check("gap_data5", log_data[5], 8'd5);
      end

      // Continuous run, stop while beat 3 of the second frame is presented.
      clear_log();
      do_start(10, 0, 0, 0);
      wait_beats(13, 200);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      wait_done(1'b0, 200);
      tick();
      check("stop_beats", 64'(log_data.size()), 64'd20);
      check("stop_frames", status_frames_sent, 16'd2);

      // Stop during an inter-frame gap ends the run on the next edge.
      clear_log();
      do_start(2, 0, 6, 0);
      wait_beats(2, 100);
      tick(2);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      tick(2);
      check("gapstop_done_at", 64'(done_cyc), 64'(stop_cyc + 1));
      check("gapstop_frames", status_frames_sent, 16'd1);
      check("gapstop_beats", 64'(log_data.size()), 64'd2);

      // Bad marker on single-beat frames.
      clear_log();
      do_start(1, 3, 0, 1);
      wait_done(1'b0, 100);
      tick();
      check("bad_beats", 64'(log_data.size()), 64'd3);
      for (int i = 0; i < 3 && i < log_data.size(); i++) begin
         check("bad_last", log_last[i], 1'b1);
         check("bad_user", log_user[i], 1'b1);
      end

      // Zero length start is ignored.
      clear_log();
      do_start(0, 5, 0, 0);
      tick(10);
      check("len0_beats", 64'(log_data.size()), 64'd0);
      check("len0_busy", status_busy, 1'b0);

      // Start while busy is ignored.
      clear_log();
      do_start(4, 2, 0, 0);
      tick(2);
      do_start(1, 1, 0, 1);
      wait_done(1'b0, 100);
      tick();
      check("busy_start_beats", 64'(log_data.size()), 64'd8);
      if (log_data.size() == 8) begin
         check("busy_start_d4", log_data[4], 8'd4);
         check("busy_start_u3", log_user[3], 1'b0);
      end

      // Reset in the middle of a frame, then restart.
      clear_log();
      do_start(5, 1, 0, 0);
      wait_beats(2, 100);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("mid_rst_valid", axis.tvalid, 1'b0);
      check("mid_rst_busy", status_busy, 1'b0);
      check("mid_rst_frames", status_frames_sent, '0);
      tick(2);
      clear_log();
      do_start(3, 1, 0, 0);
      wait_done(1'b0, 100);
      tick();
      check("restart_beats", 64'(log_data.size()), 64'd3);
      if (log_data.size() == 3) begin
         check("restart_d0", log_data[0], 8'd0);
         check("restart_d2", log_data[2], 8'd2);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
